riscv_ahb_arb: RTL and testbench
================================

RISCV_AHB_ARB -- requirements
Module: riscv_ahb_arb

Interface
REQ-001 SHALL have parameter XLEN, default 32, address/data width.
REQ-002 SHALL have parameter ROUND_ROBIN, default 0: 0 = fixed priority (M1 over M0); 1 = alternating priority on ties.
REQ-003 SHALL have port hclk, input, 1, the single clock; all state on its rising edge.
REQ-004 SHALL have port hreset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port m_hbusreq, input, 2, bus request; bit0 = M0 (instruction side), bit1 = M1 (data side).
REQ-006 SHALL have port m_hgrant, output, 2, registered one-hot grant.
REQ-007 SHALL have port m_haddr, input, 2*XLEN, per-master address; M0 occupies the low slice.
REQ-008 SHALL have port m_htrans, input, 4, per-master transfer type.
REQ-009 SHALL have port m_hsize, input, 6, per-master transfer size.
REQ-010 SHALL have port m_hburst, input, 6, per-master burst type.
REQ-011 SHALL have port m_hprot, input, 8, per-master protection.
REQ-012 SHALL have port m_hwrite, input, 2, per-master write flag.
REQ-013 SHALL have port m_hwdata, input, 2*XLEN, per-master write data.
REQ-014 SHALL have port m_hmastlock, input, 2, per-master lock request.
REQ-015 SHALL have ports haddr, htrans, hsize, hburst, hprot and hwrite, outputs, XLEN/2/3/3/4/1, slave-side address phase.
REQ-016 SHALL have port hwdata, output, XLEN, slave-side write data.
REQ-017 SHALL have port hmastlock, output, 1, slave-side lock.
REQ-018 SHALL have port hmaster, output, 1, index of the current address-phase owner.
REQ-019 SHALL have port hready, input, 1, shared transfer-done signal; hrdata/hresp are broadcast and do not pass through this block.

Function
REQ-020 SHALL hold registers gnt (one-hot, 2 bits), own_a (address owner) and own_d (data owner).
REQ-021 SHALL drive m_hgrant = gnt directly from the register.
REQ-022 SHALL update gnt only on edges where all of the following hold: hready = 1, owner m_hmastlock = 0, and owner htrans is not SEQ (2'b11) or BUSY (2'b01).
REQ-023 SHALL, when arbitrable with only one master requesting, grant that master.
REQ-024 SHALL, when arbitrable with both masters requesting and ROUND_ROBIN = 0, grant M1.
REQ-025 SHALL, when arbitrable with both masters requesting and ROUND_ROBIN = 1, grant the master not granted last.
REQ-026 SHALL, when arbitrable with no master requesting, grant M0 (default master).
REQ-027 SHALL update own_a <= index(gnt) and own_d <= own_a on every edge with hready = 1.
REQ-028 SHALL hold all state while hready = 0.
REQ-029 SHALL mux haddr, htrans, hsize, hburst, hprot, hwrite and hmastlock from master own_a.
REQ-030 SHALL mux hwdata from master own_d.
REQ-031 SHALL drive hmaster = own_a.
REQ-032 SHALL meet this latency: a request at edge N, while arbitrable, gives m_hgrant at N+1 and own_a switch at the first edge at or after N+1 with hready = 1.
REQ-033 SHALL let a granted master keep the bus while it keeps requesting and the other master does not win per REQ-024/REQ-025.
REQ-034 SHALL, if a master drops its request mid-burst, hold the grant until the burst ends (REQ-022 rule).

Reset
REQ-035 SHALL, on hreset = 1, immediately set gnt = 2'b01, own_a = 0 and own_d = 0, regardless of any in-flight transfer.
REQ-036 SHALL force htrans = IDLE (2'b00) combinationally while hreset = 1; other slave outputs follow M0.

Verification
REQ-037 SHALL cover reset: hreset pulse mid-burst -> m_hgrant = 01, hmaster = 0 and htrans = 00 in the same cycle.
REQ-038 SHALL cover a simultaneous request: m_hbusreq = 11 from idle, ROUND_ROBIN = 0 -> m_hgrant = 10 next cycle, and hmaster = 1 one hready edge later.
REQ-039 SHALL cover a wait state: M1 owns the bus, M0 requests, hready = 0 for 3 cycles -> gnt, own_a and own_d unchanged until hready = 1.
REQ-040 SHALL cover lock: M1 m_hmastlock = 1 with M0 requesting for 5 cycles -> m_hgrant stays 10; lock release -> 01 next arbitrable edge.
REQ-041 SHALL cover the data phase: M0 write at A0 followed by M1 write at A1 -> hwdata carries M0 data during A1's address phase, then M1 data.
REQ-042 SHALL cover round-robin: ROUND_ROBIN = 1 with both masters requesting continuously on single transfers -> grants alternate 10, 01, 10, ...

Source files
------------

// File: rtl/riscv_ahb_arb.sv
// Two-master AHB arbiter: M0 = instruction side, M1 = data side.
// Ports: hclk/hreset, per-master m_* buses in, m_hgrant out, muxed slave h* out, hready in.
module riscv_ahb_arb #(
  parameter int XLEN        = 32,
  parameter int ROUND_ROBIN = 0
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic [1:0]        m_hbusreq,
  output logic [1:0]        m_hgrant,
  input  logic [2*XLEN-1:0] m_haddr,
  input  logic [3:0]        m_htrans,
  input  logic [5:0]        m_hsize,
  input  logic [5:0]        m_hburst,
  input  logic [7:0]        m_hprot,
  input  logic [1:0]        m_hwrite,
  input  logic [2*XLEN-1:0] m_hwdata,
  input  logic [1:0]        m_hmastlock,
  output logic [XLEN-1:0]   haddr,
  output logic [1:0]        htrans,
  output logic [2:0]        hsize,
  output logic [2:0]        hburst,
  output logic [3:0]        hprot,
  output logic              hwrite,
  output logic [XLEN-1:0]   hwdata,
  output logic              hmastlock,
  output logic              hmaster,
  input  logic              hready
);

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_BUSY = 2'b01;
  localparam logic [1:0] T_SEQ  = 2'b11;

  logic [1:0] gnt;
  logic [1:0] gnt_nxt;
  logic       own_a;
  logic       own_d;
  logic [1:0] own_trans;
  logic       own_lock;
  logic       arb_ok;

  assign own_trans = own_a ? m_htrans[3:2] : m_htrans[1:0];
  assign own_lock  = m_hmastlock[own_a];

  // Never re-arbitrate inside a locked sequence or a burst.
  assign arb_ok = hready && !own_lock &&
                  (own_trans != T_SEQ) && (own_trans != T_BUSY);

  always_comb begin
    gnt_nxt = 2'b01;
    unique case (m_hbusreq)
      2'b01: gnt_nxt = 2'b01;
      2'b10: gnt_nxt = 2'b10;
      2'b11: begin
        if (ROUND_ROBIN != 0 && gnt[1])
          gnt_nxt = 2'b01;
        else
          gnt_nxt = 2'b10;
      end
      default: gnt_nxt = 2'b01;
    endcase
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      gnt   <= 2'b01;
      own_a <= 1'b0;
      own_d <= 1'b0;
    end else if (hready) begin
      own_a <= gnt[1];
      own_d <= own_a;
      if (arb_ok)
        gnt <= gnt_nxt;
    end
  end

  assign m_hgrant = gnt;
  assign hmaster  = own_a;

  // own_a is forced to M0 by reset, so only htrans needs masking.
  assign htrans    = hreset ? T_IDLE : own_trans;
  assign haddr     = own_a ? m_haddr[2*XLEN-1:XLEN] : m_haddr[XLEN-1:0];
  assign hsize     = own_a ? m_hsize[5:3]  : m_hsize[2:0];
  assign hburst    = own_a ? m_hburst[5:3] : m_hburst[2:0];
  assign hprot     = own_a ? m_hprot[7:4]  : m_hprot[3:0];
  assign hwrite    = m_hwrite[own_a];
  assign hmastlock = own_lock;
  assign hwdata    = own_d ? m_hwdata[2*XLEN-1:XLEN] : m_hwdata[XLEN-1:0];

endmodule

// File: tb/tb_riscv_ahb_arb.sv
// Directed bench for riscv_ahb_arb: fixed-priority and round-robin instances.
// Inputs are shared; each instance has its own outputs.
module tb_riscv_ahb_arb;

  localparam int XLEN = 32;

  logic            hclk = 1'b0;
  logic            hreset;
  logic            hready;
  logic [1:0]      m_hbusreq;
  logic [1:0]      m_hwrite;
  logic [1:0]      m_hmastlock;
  logic [XLEN-1:0] a0, a1, d0, d1;
  logic [1:0]      t0, t1;
  logic [2*XLEN-1:0] m_haddr, m_hwdata;
  logic [3:0]      m_htrans;
  logic [5:0]      m_hsize, m_hburst;
  logic [7:0]      m_hprot;

  assign m_haddr  = {a1, a0};
  assign m_hwdata = {d1, d0};
  assign m_htrans = {t1, t0};

  logic [1:0]      gnt0, gnt1;
  logic [XLEN-1:0] haddr0, haddr1, hwdata0, hwdata1;
  logic [1:0]      htrans0, htrans1;
  logic [2:0]      hsize0, hsize1, hburst0, hburst1;
  logic [3:0]      hprot0, hprot1;
  logic            hwrite0, hwrite1, hlock0, hlock1, hmaster0, hmaster1;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  always #5 hclk = ~hclk;

  riscv_ahb_arb #(.XLEN(XLEN), .ROUND_ROBIN(0)) dut (
    .hclk(hclk), .hreset(hreset),
    .m_hbusreq(m_hbusreq), .m_hgrant(gnt0),
    .m_haddr(m_haddr), .m_htrans(m_htrans),
    .m_hsize(m_hsize), .m_hburst(m_hburst),
    .m_hprot(m_hprot), .m_hwrite(m_hwrite),
    .m_hwdata(m_hwdata), .m_hmastlock(m_hmastlock),
    .haddr(haddr0), .htrans(htrans0),
    .hsize(hsize0), .hburst(hburst0),
    .hprot(hprot0), .hwrite(hwrite0),
    .hwdata(hwdata0), .hmastlock(hlock0),
    .hmaster(hmaster0), .hready(hready)
  );

  riscv_ahb_arb #(.XLEN(XLEN), .ROUND_ROBIN(1)) dut_rr (
    .hclk(hclk), .hreset(hreset),
    .m_hbusreq(m_hbusreq), .m_hgrant(gnt1),
    .m_haddr(m_haddr), .m_htrans(m_htrans),
    .m_hsize(m_hsize), .m_hburst(m_hburst),
    .m_hprot(m_hprot), .m_hwrite(m_hwrite),
    .m_hwdata(m_hwdata), .m_hmastlock(m_hmastlock),
    .haddr(haddr1), .htrans(htrans1),
    .hsize(hsize1), .hburst(hburst1),
    .hprot(hprot1), .hwrite(hwrite1),
    .hwdata(hwdata1), .hmastlock(hlock1),
    .hmaster(hmaster1), .hready(hready)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge hclk);
    #1;
  endtask

  initial begin
    hreset      = 1'b1;
    hready      = 1'b1;
    m_hbusreq   = 2'b00;
    m_hwrite    = 2'b00;
    m_hmastlock = 2'b00;
    m_hsize     = 6'b010_010;
    m_hburst    = 6'b000_000;
    m_hprot     = 8'h33;
    a0 = 32'h1000; a1 = 32'h2000;
    d0 = 32'h0;    d1 = 32'h0;
    t0 = 2'b10;    t1 = 2'b00;
    #1;
    chk("rst_gnt",     32'(gnt0),     32'h1);
    chk("rst_hmaster", 32'(hmaster0), 32'h0);
    chk("rst_htrans",  32'(htrans0),  32'h0);
    chk("rst_haddr",   haddr0,        32'h1000);
    chk("rst_gnt_rr",  32'(gnt1),     32'h1);

    tick; tick;
    hreset = 1'b0;
    t0 = 2'b00;

    // Simultaneous request from idle.
    m_hbusreq = 2'b11;
    tick;
    chk("sim_gnt",     32'(gnt0),     32'h2);
    chk("sim_own_old", 32'(hmaster0), 32'h0);
    tick;
    chk("sim_own_new", 32'(hmaster0), 32'h1);
    t1 = 2'b10;
    #1;
    chk("sim_haddr",  haddr0,        32'h2000);
    chk("sim_htrans", 32'(htrans0),  32'h2);

    // Wait states: nothing moves while hready is low.
    m_hbusreq = 2'b01;
    hready    = 1'b0;
    d0 = 32'hAAAA;
    d1 = 32'hBBBB;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("ws_gnt",     32'(gnt0),     32'h2);
      chk("ws_hmaster", 32'(hmaster0), 32'h1);
      chk("ws_hwdata",  hwdata0,       32'hAAAA);
    end
    hready = 1'b1;
    tick;
    chk("ws_rel_gnt",     32'(gnt0),     32'h1);
    chk("ws_rel_hmaster", 32'(hmaster0), 32'h1);
    chk("ws_rel_hwdata",  hwdata0,       32'hBBBB);

    // Lock: M1 keeps the bus despite M0 requesting.
    t1 = 2'b00;
    m_hbusreq = 2'b10;
    tick;
    tick;
    chk("lk_gnt0",    32'(gnt0),     32'h2);
    chk("lk_hmaster", 32'(hmaster0), 32'h1);
    m_hmastlock = 2'b10;
    t1 = 2'b10;
    m_hbusreq = 2'b01;
    #1;
    chk("lk_hmastlock", 32'(hlock0), 32'h1);
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("lk_gnt_hold", 32'(gnt0), 32'h2);
    end
    m_hmastlock = 2'b00;
    t1 = 2'b00;
    tick;
    chk("lk_rel_gnt", 32'(gnt0), 32'h1);

    // Data phase follows the previous address owner.
    m_hbusreq = 2'b10;
    t0 = 2'b10;
    m_hwrite = 2'b01;
    a0 = 32'h100;
    d0 = 32'hD0D0_0000;
    tick;
    chk("dp_a0_hmaster", 32'(hmaster0), 32'h0);
    chk("dp_a0_haddr",   haddr0,        32'h100);
    chk("dp_a0_htrans",  32'(htrans0),  32'h2);
    chk("dp_a0_hwrite",  32'(hwrite0),  32'h1);
    t0 = 2'b00;
    t1 = 2'b10;
    m_hwrite = 2'b10;
    a1 = 32'h200;
    d1 = 32'hD1D1_1111;
    tick;
    chk("dp_a1_hmaster", 32'(hmaster0), 32'h1);
    chk("dp_a1_haddr",   haddr0,        32'h200);
    chk("dp_a1_hwdata",  hwdata0,       32'hD0D0_0000);
    t1 = 2'b00;
    m_hbusreq = 2'b00;
    m_hwrite = 2'b00;
    tick;
    chk("dp_d1_hwdata", hwdata0, 32'hD1D1_1111);

    // Burst: dropping the request mid-burst keeps the grant.
    m_hbusreq = 2'b10;
    t1 = 2'b10;
    tick;
    tick;
    t1 = 2'b11;
    m_hbusreq = 2'b01;
    tick;
    chk("bu_seq_gnt", 32'(gnt0), 32'h2);
    t1 = 2'b01;
    tick;
    chk("bu_busy_gnt", 32'(gnt0),     32'h2);
    chk("bu_hmaster",  32'(hmaster0), 32'h1);

    // Reset in the middle of the burst.
    t0 = 2'b10;
    t1 = 2'b11;
    hreset = 1'b1;
    #1;
    chk("mr_gnt",     32'(gnt0),     32'h1);
    chk("mr_hmaster", 32'(hmaster0), 32'h0);
    chk("mr_htrans",  32'(htrans0),  32'h0);
    chk("mr_gnt_rr",  32'(gnt1),     32'h1);
    tick;
    hreset = 1'b0;
    t0 = 2'b00;
    t1 = 2'b00;

    // Both requesting: fixed priority holds M1, round-robin alternates.
    m_hbusreq = 2'b11;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("rr_gnt", 32'(gnt1), (i % 2 == 0) ? 32'h2 : 32'h1);
      chk("fp_gnt", 32'(gnt0), 32'h2);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
